// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: opcode constants, ALUOp/ALUSrc encodings, 64-bit data type and pipeline records.
// Pipeline records are shared between the execution stage and the cpu_control decoder.
package legv8_pkg;

  typedef logic [63:0] dword_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_PASSB = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUSRC_REG   = 2'b00,
    ALUSRC_SEXT  = 2'b01,
    ALUSRC_IMM12 = 2'b10,
    ALUSRC_REG2  = 2'b11
  } alu_src_e;

  typedef struct packed {
    dword_t      pc;
    logic [10:0] opcode;
    logic [11:0] imm12;
    logic [4:0]  rd;
    dword_t      sign_ext;
    dword_t      data1;
    dword_t      data2;
    logic [1:0]  alu_src;
    logic [1:0]  alu_op;
    logic        b;
    logic        bz;
    logic        bnz;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic        reg_write;
  } ex_reg_t;

  typedef struct packed {
    dword_t     alu_res;
    dword_t     store_dat;
    logic [4:0] rd;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_write;
  } mem_reg_t;

  function automatic dword_t zext_imm12(input logic [11:0] imm);
    return {52'd0, imm};
  endfunction

endpackage

// File: rtl/legv8_alu.sv
// Combinational LEGv8 ALU: add, pass-B, R-type and I-type ops selected by ALUOp and opcode.
// Zero latency; unknown opcodes produce 0.
module legv8_alu
  import legv8_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode,
  output logic [63:0] result
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALUOP_ADD:   result = a + b;
      ALUOP_PASSB: result = b;
      ALUOP_RTYPE: begin
        case (opcode)
          OP_ADD:  result = a + b;
          OP_SUB:  result = a - b;
          OP_AND:  result = a & b;
          OP_ORR:  result = a | b;
          default: result = '0;
        endcase
      end
      ALUOP_ITYPE: begin
        // I-type opcodes are only 10 bits; bit 21 belongs to the immediate.
        case (opcode[10:1])
          OP_ADDI: result = a + b;
          OP_SUBI: result = a - b;
          default: result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execution.sv
// LEGv8 EX/MEM/WB slice: branch results 1 cycle and write-back 2 cycles after capture.
// No stall or backpressure; one instruction accepted every cycle.
module execution
  import legv8_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic [63:0] sign_ext_in,
  input  logic [63:0] data1_in,
  input  logic [63:0] data2_in,
  input  logic [1:0]  alu_src_in,
  input  logic [1:0]  alu_op_in,
  input  logic        b_in,
  input  logic        bz_in,
  input  logic        bnz_in,
  input  logic        mem_write_in,
  input  logic        mem_read_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  output logic [63:0] data2_write,
  output logic [4:0]  reg2_write,
  output logic        old_reg_write,
  output logic [63:0] branch_address,
  output logic        pc_src
);

  localparam int AW = $clog2(MEM_WORDS);

  ex_reg_t       ex_d, ex_q;
  mem_reg_t      mem_d, mem_q;
  dword_t        op_b, alu_res, rd_dat;
  dword_t        br_addr_d, br_addr_q;
  logic          taken_d, taken_q;
  dword_t        wb_dat_d, wb_dat_q;
  logic [4:0]    wb_rd_d, wb_rd_q;
  logic          wb_vld_d, wb_vld_q;
  dword_t        dmem_q [MEM_WORDS];
  logic [AW-1:0] mem_idx;
  logic          unused_instr;

  assign unused_instr = ^instr_in[9:5];

  always_comb begin
    ex_d            = '0;
    ex_d.pc         = pc_in;
    ex_d.opcode     = instr_in[31:21];
    ex_d.imm12      = instr_in[21:10];
    ex_d.rd         = instr_in[4:0];
    ex_d.sign_ext   = sign_ext_in;
    ex_d.data1      = data1_in;
    ex_d.data2      = data2_in;
    ex_d.alu_src    = alu_src_in;
    ex_d.alu_op     = alu_op_in;
    ex_d.b          = b_in;
    ex_d.bz         = bz_in;
    ex_d.bnz        = bnz_in;
    ex_d.mem_write  = mem_write_in;
    ex_d.mem_read   = mem_read_in;
    ex_d.mem_to_reg = mem_to_reg_in;
    ex_d.reg_write  = reg_write_in;
  end

  always_comb begin
    op_b = ex_q.data2;
    case (ex_q.alu_src)
      ALUSRC_REG, ALUSRC_REG2: op_b = ex_q.data2;
      ALUSRC_SEXT:             op_b = ex_q.sign_ext;
      ALUSRC_IMM12:            op_b = zext_imm12(ex_q.imm12);
      default:                 op_b = ex_q.data2;
    endcase
  end

  legv8_alu u_alu (
    .a      (ex_q.data1),
    .b      (op_b),
    .alu_op (ex_q.alu_op),
    .opcode (ex_q.opcode),
    .result (alu_res)
  );

  always_comb begin
    br_addr_d = ex_q.pc + (ex_q.sign_ext << 2);
    taken_d   = ex_q.b | (ex_q.bz & (ex_q.data2 == '0)) | (ex_q.bnz & (ex_q.data2 != '0));

    mem_d            = '0;
    mem_d.alu_res    = alu_res;
    mem_d.store_dat  = ex_q.data2;
    mem_d.rd         = ex_q.rd;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.reg_write  = ex_q.reg_write;
  end

  // Read is asynchronous and sampled at the same edge as the write, so a
  // simultaneous read sees the pre-write contents.
  assign mem_idx = mem_q.alu_res[AW+2:3];

  always_comb begin
    rd_dat   = mem_q.mem_read ? dmem_q[mem_idx] : '0;
    wb_dat_d = mem_q.mem_to_reg ? rd_dat : mem_q.alu_res;
    wb_rd_d  = mem_q.rd;
    wb_vld_d = mem_q.reg_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      br_addr_q <= '0;
      taken_q   <= 1'b0;
      wb_dat_q  <= '0;
      wb_rd_q   <= '0;
      wb_vld_q  <= 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) begin
        dmem_q[i] <= '0;
      end
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      br_addr_q <= br_addr_d;
      taken_q   <= taken_d;
      wb_dat_q  <= wb_dat_d;
      wb_rd_q   <= wb_rd_d;
      wb_vld_q  <= wb_vld_d;
      if (mem_q.mem_write) begin
        dmem_q[mem_idx] <= mem_q.store_dat;
      end
    end
  end

  assign data2_write    = wb_dat_q;
  assign reg2_write     = wb_rd_q;
  assign old_reg_write  = wb_vld_q;
  assign branch_address = br_addr_q;
  assign pc_src         = taken_q;

endmodule

// File: tb/tb_execution.sv
// Scoreboard bench for execution: directed vectors push expected write-backs and
// branches with their due cycle; a negedge monitor pops and compares on each strobe.
module tb_execution;

  localparam logic [10:0] T_ADD  = 11'b10001011000;
  localparam logic [10:0] T_SUB  = 11'b11001011000;
  localparam logic [10:0] T_AND  = 11'b10001010000;
  localparam logic [10:0] T_ORR  = 11'b10101010000;
  localparam logic [10:0] T_BAD  = 11'b11111111111;
  localparam logic [9:0]  T_ADDI = 10'b1001000100;
  localparam logic [9:0]  T_SUBI = 10'b1101000100;

  // flag vector order: {b, bz, bnz, mem_write, mem_read, mem_to_reg, reg_write}
  localparam logic [6:0] F_B   = 7'b1000000;
  localparam logic [6:0] F_BZ  = 7'b0100000;
  localparam logic [6:0] F_BNZ = 7'b0010000;
  localparam logic [6:0] F_MW  = 7'b0001000;
  localparam logic [6:0] F_MR  = 7'b0000100;
  localparam logic [6:0] F_M2R = 7'b0000010;
  localparam logic [6:0] F_RW  = 7'b0000001;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    logic [63:0] dat;
  } wb_exp_t;

  typedef struct {
    int unsigned cyc;
    logic [63:0] addr;
  } br_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_in, sign_ext_in, data1_in, data2_in;
  logic [31:0] instr_in;
  logic [1:0]  alu_src_in, alu_op_in;
  logic        b_in, bz_in, bnz_in, mem_write_in, mem_read_in, mem_to_reg_in, reg_write_in;
  logic [63:0] data2_write, branch_address;
  logic [4:0]  reg2_write;
  logic        old_reg_write, pc_src;

  int          checks = 0;
  int          failures = 0;
  int unsigned ncyc = 0;
  wb_exp_t     wb_q[$];
  br_exp_t     br_q[$];

  execution #(.MEM_WORDS(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .instr_in       (instr_in),
    .sign_ext_in    (sign_ext_in),
    .data1_in       (data1_in),
    .data2_in       (data2_in),
    .alu_src_in     (alu_src_in),
    .alu_op_in      (alu_op_in),
    .b_in           (b_in),
    .bz_in          (bz_in),
    .bnz_in         (bnz_in),
    .mem_write_in   (mem_write_in),
    .mem_read_in    (mem_read_in),
    .mem_to_reg_in  (mem_to_reg_in),
    .reg_write_in   (reg_write_in),
    .data2_write    (data2_write),
    .reg2_write     (reg2_write),
    .old_reg_write  (old_reg_write),
    .branch_address (branch_address),
    .pc_src         (pc_src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [10:0] op, input logic [4:0] rd);
    return {op, 16'h0000, rd};
  endfunction

  function automatic logic [31:0] mk_i(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rd);
    return {op, imm, 5'd0, rd};
  endfunction

  task automatic zero_inputs();
    pc_in = '0; instr_in = '0; sign_ext_in = '0; data1_in = '0; data2_in = '0;
    alu_src_in = '0; alu_op_in = '0;
    {b_in, bz_in, bnz_in, mem_write_in, mem_read_in, mem_to_reg_in, reg_write_in} = '0;
  endtask

  // Drives one instruction for one capture edge; 'live' = 0 means it will be
  // killed by reset, so no write-back is expected.
  task automatic issue(input logic [63:0] pc, input logic [31:0] ins, input logic [63:0] se,
                       input logic [63:0] d1, input logic [63:0] d2,
                       input logic [1:0] as, input logic [1:0] ao, input logic [6:0] fl,
                       input logic live, input logic [63:0] exp_wb,
                       input logic exp_tk, input logic [63:0] exp_ba);
    int unsigned cap;
    pc_in = pc; instr_in = ins; sign_ext_in = se; data1_in = d1; data2_in = d2;
    alu_src_in = as; alu_op_in = ao;
    {b_in, bz_in, bnz_in, mem_write_in, mem_read_in, mem_to_reg_in, reg_write_in} = fl;
    @(posedge clk); #1;
    cap = ncyc;
    if (live && fl[0]) wb_q.push_back('{cap + 2, ins[4:0], exp_wb});
    if (live && exp_tk) br_q.push_back('{cap + 1, exp_ba});
    zero_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data2_write"}, data2_write, 64'd0);
    chk({tag, "_reg2_write"}, {59'd0, reg2_write}, 64'd0);
    chk({tag, "_old_reg_write"}, {63'd0, old_reg_write}, 64'd0);
    chk({tag, "_branch_address"}, branch_address, 64'd0);
    chk({tag, "_pc_src"}, {63'd0, pc_src}, 64'd0);
  endtask

  always @(negedge clk) begin
    if (old_reg_write) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected_strobe", {63'd0, old_reg_write}, 64'd0);
      end else begin
        wb_exp_t e;
        e = wb_q.pop_front();
        chk("wb_cycle", 64'(ncyc), 64'(e.cyc));
        chk("wb_rd", {59'd0, reg2_write}, {59'd0, e.rd});
        chk("wb_data", data2_write, e.dat);
      end
    end
    if (pc_src) begin
      if (br_q.size() == 0) begin
        chk("br_unexpected_pc_src", {63'd0, pc_src}, 64'd0);
      end else begin
        br_exp_t e;
        e = br_q.pop_front();
        chk("br_cycle", 64'(ncyc), 64'(e.cyc));
        chk("br_address", branch_address, e.addr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    zero_inputs();
    rst = 1'b1;
    idle(3);
    chk_outputs_zero("reset");
    rst = 1'b0;

    // ALU vectors (back-to-back)
    issue(0, mk_r(T_ADD, 5'd3), 0, 64'd5, 64'd7, 2'b00, 2'b10, F_RW, 1, 64'd12, 0, 0);
    issue(0, mk_r(T_SUB, 5'd4), 0, 64'd0, 64'd1, 2'b00, 2'b10, F_RW, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    issue(0, mk_r(T_AND, 5'd5), 0, 64'hF0F0, 64'hFF00, 2'b00, 2'b10, F_RW, 1, 64'hF000, 0, 0);
    issue(0, mk_r(T_ORR, 5'd6), 0, 64'hF0, 64'h0F, 2'b00, 2'b10, F_RW, 1, 64'hFF, 0, 0);
    issue(0, mk_r(T_BAD, 5'd7), 0, 64'd3, 64'd4, 2'b00, 2'b10, F_RW, 1, 64'd0, 0, 0);
    issue(0, mk_i(T_ADDI, 12'hFFF, 5'd8), 0, 64'd1, 64'd99, 2'b10, 2'b11, F_RW, 1, 64'h1000, 0, 0);
    issue(0, mk_i(T_SUBI, 12'h020, 5'd9), 0, 64'h10, 64'd99, 2'b10, 2'b11, F_RW, 1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0);
    issue(0, mk_r(T_BAD, 5'd10), 64'h1234, 64'd50, 64'd60, 2'b01, 2'b01, F_RW, 1, 64'h1234, 0, 0);
    issue(0, mk_r(T_BAD, 5'd31), 0, 64'd100, 64'd23, 2'b11, 2'b00, F_RW, 1, 64'd123, 0, 0);

    // Store then loads: same address, low bits ignored, upper bits wrap
    issue(0, mk_r(T_BAD, 5'd1), 64'd8, 64'h10, 64'hABCD, 2'b01, 2'b00, F_MW, 1, 0, 0, 0);
    issue(0, mk_r(T_BAD, 5'd11), 64'd8, 64'h10, 64'd0, 2'b01, 2'b00, F_MR | F_M2R | F_RW, 1, 64'hABCD, 0, 0);
    issue(0, mk_r(T_BAD, 5'd12), 64'hF, 64'h10, 64'd0, 2'b01, 2'b00, F_MR | F_M2R | F_RW, 1, 64'hABCD, 0, 0);
    issue(0, mk_r(T_BAD, 5'd13), 64'h18, 64'h100, 64'd0, 2'b01, 2'b00, F_MR | F_M2R | F_RW, 1, 64'hABCD, 0, 0);
    // Simultaneous write+read returns the old word; next load sees the new one
    issue(0, mk_r(T_BAD, 5'd14), 64'd8, 64'h10, 64'h5555, 2'b01, 2'b00, F_MW | F_MR | F_M2R | F_RW, 1, 64'hABCD, 0, 0);
    issue(0, mk_r(T_BAD, 5'd15), 64'd8, 64'h10, 64'd0, 2'b01, 2'b00, F_MR | F_M2R | F_RW, 1, 64'h5555, 0, 0);

    // Branches
    issue(64'h100, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'd0, 2'b00, 2'b01, F_BZ, 1, 0, 1, 64'hF8);
    issue(64'h100, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 64'd1, 2'b00, 2'b01, F_BZ, 1, 0, 0, 0);
    issue(64'h40, 0, 64'd3, 0, 64'd5, 2'b00, 2'b01, F_BNZ, 1, 0, 1, 64'h4C);
    issue(64'h40, 0, 64'd3, 0, 64'd0, 2'b00, 2'b01, F_BNZ, 1, 0, 0, 0);
    issue(64'h0, 0, 64'd4, 0, 64'd0, 2'b00, 2'b01, F_B, 1, 0, 1, 64'h10);
    issue(64'h200, 0, 64'd1, 0, 64'd0, 2'b00, 2'b01, F_B, 1, 0, 1, 64'h204);
    idle(4);

    // Reset mid-stream: ADD and STUR in flight are discarded
    issue(0, mk_r(T_ADD, 5'd20), 0, 64'd1, 64'd1, 2'b00, 2'b10, F_RW, 0, 0, 0, 0);
    issue(0, mk_r(T_BAD, 5'd2), 64'd8, 64'h20, 64'h77, 2'b01, 2'b00, F_MW, 0, 0, 0, 0);
    rst = 1'b1;
    idle(1);
    chk_outputs_zero("midreset1");
    idle(1);
    chk_outputs_zero("midreset2");
    rst = 1'b0;

    // Memory must be all zero after reset, and results on the normal schedule
    issue(0, mk_r(T_BAD, 5'd16), 64'd8, 64'h20, 64'd0, 2'b01, 2'b00, F_MR | F_M2R | F_RW, 1, 64'd0, 0, 0);
    issue(0, mk_r(T_BAD, 5'd17), 64'd8, 64'h10, 64'd0, 2'b01, 2'b00, F_MR | F_M2R | F_RW, 1, 64'd0, 0, 0);
    issue(0, mk_r(T_ADD, 5'd18), 0, 64'd40, 64'd2, 2'b00, 2'b10, F_RW, 1, 64'd42, 0, 0);
    idle(5);

    chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    chk("br_queue_drained", 64'(br_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
